// File: rtl/seq_div16by8.sv
// Restoring shift-subtract divider: 2*DW-bit dividend / DW-bit divisor -> quotient, remainder.
// Latency: done pulses in the cycle after the 2*DW-th CALC edge; a divide by zero reports on the accepting edge.
// Backpressure: start is sampled only when busy=0 and is ignored while a division runs.
//
// Ports:
//   clk, rst_n       rising-edge clock, asynchronous active-low reset
//   start            request; dividend/divisor are captured on the accepting edge
//   busy             high while the iterative division is running
//   done             one-cycle pulse; quotient/remainder/div_zero updated with it
//   quotient         2*DW-bit registered result (all ones on divide by zero)
//   remainder        DW-bit registered result (zero on divide by zero)
//   div_zero         set when the last accepted request had divisor==0
module seq_div16by8 #(
    parameter int DW = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [2*DW-1:0]   dividend,
    input  logic [DW-1:0]     divisor,
    output logic              busy,
    output logic              done,
    output logic [2*DW-1:0]   quotient,
    output logic [DW-1:0]     remainder,
    output logic              div_zero
);

    localparam int NW = 2 * DW;
    localparam int CW = $clog2(NW);

    typedef enum logic {
        IDLE = 1'b0,
        CALC = 1'b1
    } state_t;

    state_t           state;
    logic [NW-1:0]    n_reg;    // dividend shifting out, quotient bits shifting in
    logic [DW-1:0]    d_reg;
    logic [DW-1:0]    r_reg;    // partial remainder, always < divisor between steps
    logic [CW-1:0]    cnt;

    logic [DW:0]      r_shift;
    logic             r_ge;
    logic [DW-1:0]    r_next;
    logic [NW-1:0]    n_next;
    logic             last_step;

    // One restoring step. The shifted remainder needs DW+1 bits, but after a
    // successful subtract the result is below the divisor, so the difference
    // fits in DW bits and can be computed without the top bit.
    always_comb begin
        r_shift   = {r_reg, n_reg[NW-1]};
        r_ge      = (r_shift >= {1'b0, d_reg});
        r_next    = r_ge ? (r_shift[DW-1:0] - d_reg) : r_shift[DW-1:0];
        n_next    = {n_reg[NW-2:0], r_ge};
        last_step = (cnt == CW'(NW - 1));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            n_reg     <= '0;
            d_reg     <= '0;
            r_reg     <= '0;
            cnt       <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            quotient  <= '0;
            remainder <= '0;
            div_zero  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        if (divisor == '0) begin
                            // Answer immediately without entering CALC.
                            quotient  <= '1;
                            remainder <= '0;
                            div_zero  <= 1'b1;
                            done      <= 1'b1;
                        end else begin
                            n_reg <= dividend;
                            d_reg <= divisor;
                            r_reg <= '0;
                            cnt   <= '0;
                            busy  <= 1'b1;
                            state <= CALC;
                        end
                    end
                end
                CALC: begin
                    n_reg <= n_next;
                    r_reg <= r_next;
                    cnt   <= cnt + 1'b1;
                    if (last_step) begin
                        quotient  <= n_next;
                        remainder <= r_next;
                        div_zero  <= 1'b0;
                        done      <= 1'b1;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_div16by8.sv
// Self-checking bench for seq_div16by8: directed cases, reset abort, handshake
// behaviour, multiplier round trips and random operands against an arithmetic model.
module tb_seq_div16by8;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [15:0] dividend;
    logic [7:0]  divisor;
    logic        busy;
    logic        done;
    logic [15:0] quotient;
    logic [7:0]  remainder;
    logic        div_zero;

    int total = 0;
    int bad   = 0;

    seq_div16by8 #(.DW(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .dividend  (dividend),
        .divisor   (divisor),
        .busy      (busy),
        .done      (done),
        .quotient  (quotient),
        .remainder (remainder),
        .div_zero  (div_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    // Reference: plain integer division, with the divide-by-zero convention.
    task automatic model(input int unsigned a, input int unsigned b,
                         output int unsigned q, output int unsigned r, output int unsigned z);
        if (b == 0) begin
            q = 16'hFFFF; r = 0; z = 1;
        end else begin
            q = a / b; r = a % b; z = 0;
        end
    endtask

    // Issue one request, then count edges to done and busy cycles, check results.
    task automatic run_div(input string tag, input logic [15:0] a, input logic [7:0] b);
        int unsigned eq, er, ez;
        int edges, busy_cnt;
        model(a, b, eq, er, ez);
        @(negedge clk);
        start = 1'b1; dividend = a; divisor = b;
        @(posedge clk); #1;
        edges    = 0;
        busy_cnt = busy ? 1 : 0;
        start    = 1'b0;
        dividend = 16'($urandom);
        divisor  = 8'($urandom);
        while (!done && edges < 40) begin
            @(posedge clk); #1;
            edges++;
            if (busy) busy_cnt++;
        end
        chk({tag, "_done_seen"}, done, 1);
        chk({tag, "_latency"}, edges, (b == 0) ? 0 : 16);
        chk({tag, "_busy_cycles"}, busy_cnt, (b == 0) ? 0 : 16);
        chk({tag, "_q"}, quotient, eq);
        chk({tag, "_r"}, remainder, er);
        chk({tag, "_dz"}, div_zero, ez);
        @(posedge clk); #1;
        chk({tag, "_done_pulse"}, done, 0);
    endtask

    // start held high across two divisions while operands keep changing.
    task automatic hold_test();
        logic [15:0] a1, a2;
        logic [7:0]  b1, b2;
        int unsigned eq, er, ez;
        int edges;
        a1 = 16'($urandom); b1 = 8'($urandom_range(1, 255));
        @(negedge clk);
        start = 1'b1; dividend = a1; divisor = b1;
        @(posedge clk); #1;
        edges = 0;
        dividend = 16'($urandom); divisor = 8'($urandom);
        while (!done && edges < 40) begin
            @(posedge clk); #1;
            edges++;
            if (!done) begin dividend = 16'($urandom); divisor = 8'($urandom); end
        end
        model(a1, b1, eq, er, ez);
        chk("hold1_latency", edges, 16);
        chk("hold1_q", quotient, eq);
        chk("hold1_r", remainder, er);
        // start still high during the done cycle: these operands are taken next edge
        a2 = 16'($urandom); b2 = 8'($urandom_range(1, 255));
        dividend = a2; divisor = b2;
        @(posedge clk); #1;
        edges = 0;
        chk("hold2_accept_busy", busy, 1);
        chk("hold2_done_low", done, 0);
        dividend = 16'($urandom); divisor = 8'($urandom);
        while (!done && edges < 40) begin
            @(posedge clk); #1;
            edges++;
            if (!done) begin dividend = 16'($urandom); divisor = 8'($urandom); end
        end
        start = 1'b0;
        model(a2, b2, eq, er, ez);
        chk("hold2_latency", edges, 16);
        chk("hold2_q", quotient, eq);
        chk("hold2_r", remainder, er);
        chk("hold2_dz", div_zero, 0);
    endtask

    task automatic reset_abort_test();
        int dones;
        @(negedge clk);
        start = 1'b1; dividend = 16'd1000; divisor = 8'd7;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("rst_mid_busy", busy, 0);
        chk("rst_mid_done", done, 0);
        chk("rst_mid_q", quotient, 0);
        chk("rst_mid_r", remainder, 0);
        chk("rst_mid_dz", div_zero, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        dones = 0;
        repeat (20) begin
            @(posedge clk); #1;
            if (done || busy) dones++;
        end
        chk("rst_no_done_after", dones, 0);
        run_div("after_rst", 16'd1000, 8'd7);
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; dividend = '0; divisor = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_q", quotient, 0);
        chk("rst_r", remainder, 0);
        chk("rst_dz", div_zero, 0);
        @(negedge clk) rst_n = 1'b1;

        run_div("basic", 16'd1000, 8'd7);
        run_div("max_by_max", 16'd65535, 8'd255);
        run_div("max_by_one", 16'd65535, 8'd1);
        run_div("small_by_big", 16'd100, 8'd200);
        run_div("zero_num", 16'd0, 8'd9);
        run_div("div0", 16'd1234, 8'd0);
        run_div("after_div0", 16'd20, 8'd3);

        reset_abort_test();
        hold_test();

        // Multiplier round trips: every a, a few divisors each, exact and with max remainder.
        for (int a = 0; a < 100; a++) begin
            for (int k = 0; k < 2; k++) begin
                int b;
                b = (a % 10 == 0) ? ((k == 0) ? 1 : 99) : int'($urandom_range(1, 99));
                run_div("rt_exact", 16'(a * b), 8'(b));
                run_div("rt_rem", 16'(a * b + b - 1), 8'(b));
            end
        end

        // Random operands, occasional zero divisor.
        for (int i = 0; i < 150; i++) begin
            logic [15:0] a;
            logic [7:0]  b;
            a = 16'($urandom);
            b = ($urandom_range(0, 15) == 0) ? 8'd0 : 8'($urandom);
            run_div("rand", a, b);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not complete, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

endmodule
